// File: rtl/core_phase_pkg.sv
// core_phase_pkg: phase encodings shared by the phase sequencer and its users
package core_phase_pkg;

    typedef enum logic [1:0] {
        PHASE_HALT  = 2'd0,
        PHASE_FETCH = 2'd1,
        PHASE_MEM   = 2'd2,
        PHASE_WB    = 2'd3
    } phase_e;

endpackage

// File: rtl/phase_wait_timer.sv
// phase_wait_timer: loadable saturating wait counter, done once the count reaches the latched limit
module phase_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] lim_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            lim_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
            lim_q <= limit;
        end else if (!(&cnt_q)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign done = cnt_q >= lim_q;

endmodule

// File: rtl/core_phase_sequencer.sv
// core_phase_sequencer: clock-enable phase controller (FETCH/MEM/WB) with wait states, run/step and instret
module core_phase_sequencer
    import core_phase_pkg::*;
#(
    parameter int WAIT_W    = 4,
    parameter bit SKIP_DMEM = 1'b0,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic [WAIT_W-1:0] imem_wait,
    input  logic [WAIT_W-1:0] dmem_wait,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              imem_en,
    output logic              dmem_en,
    output logic              pc_en,
    output logic [1:0]        phase,
    output logic              busy,
    output logic [CNT_W-1:0]  instret
);

    phase_e              state_q, state_d;
    logic                imem_en_q, dmem_en_q, pc_en_q, busy_q;
    logic [CNT_W-1:0]    instret_q;
    logic                start;
    logic [WAIT_W-1:0]   limit;
    logic                done;

    phase_wait_timer #(.W(WAIT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .limit (limit),
        .done  (done)
    );

    // The timer is restarted on the edge that enters FETCH or MEM, so the wait is latched at entry
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        limit   = imem_wait;
        case (state_q)
            PHASE_HALT: begin
                state_d = (run || step) ? PHASE_FETCH : PHASE_HALT;
                start   = run || step;
            end
            PHASE_FETCH: begin
                state_d = !done ? PHASE_FETCH : (SKIP_DMEM && !dmem_req) ? PHASE_WB : PHASE_MEM;
                start   = state_d == PHASE_MEM;
                limit   = dmem_wait;
            end
            PHASE_MEM: begin
                state_d = (done && dmem_ready) ? PHASE_WB : PHASE_MEM;
            end
            PHASE_WB: begin
                state_d = run ? PHASE_FETCH : PHASE_HALT;
                start   = run;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PHASE_HALT;
            imem_en_q <= 1'b0;
            dmem_en_q <= 1'b0;
            pc_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            imem_en_q <= state_d == PHASE_FETCH && state_q != PHASE_FETCH;
            dmem_en_q <= state_d == PHASE_MEM && state_q != PHASE_MEM;
            pc_en_q   <= state_d == PHASE_WB;
            busy_q    <= state_d != PHASE_HALT;
            instret_q <= instret_q + CNT_W'(pc_en_q);
        end
    end

    assign imem_en = imem_en_q;
    assign dmem_en = dmem_en_q;
    assign pc_en   = pc_en_q;
    assign phase   = state_q;
    assign busy    = busy_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_core_phase_sequencer.sv
// tb_core_phase_sequencer: directed checks of phase sequencing, waits, skip, stall, step and reset
module tb_core_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  imem_wait = '0;
    logic [3:0]  dmem_wait = '0;
    logic        dmem_req = 1'b1;
    logic        dmem_ready = 1'b1;
    logic        imem_en, dmem_en, pc_en, busy;
    logic [1:0]  phase;
    logic [31:0] instret;
    logic        imem_en_s, dmem_en_s, pc_en_s, busy_s;
    logic [1:0]  phase_s;
    logic [31:0] instret_s;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    core_phase_sequencer #(.WAIT_W(4), .SKIP_DMEM(1'b0), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step),
        .imem_wait(imem_wait), .dmem_wait(dmem_wait), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .imem_en(imem_en), .dmem_en(dmem_en), .pc_en(pc_en), .phase(phase), .busy(busy), .instret(instret)
    );

    core_phase_sequencer #(.WAIT_W(4), .SKIP_DMEM(1'b1), .CNT_W(32)) dut_s (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step),
        .imem_wait(imem_wait), .dmem_wait(dmem_wait), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .imem_en(imem_en_s), .dmem_en(dmem_en_s), .pc_en(pc_en_s), .phase(phase_s), .busy(busy_s), .instret(instret_s)
    );

    // {phase, imem_en, dmem_en, pc_en, busy}
    wire logic [5:0] obs   = {phase, imem_en, dmem_en, pc_en, busy};
    wire logic [5:0] obs_s = {phase_s, imem_en_s, dmem_en_s, pc_en_s, busy_s};

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        step = 1'b0;
        imem_wait = '0;
        dmem_wait = '0;
        dmem_req = 1'b1;
        dmem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 6'b00_0000) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 6'b00_0000); end
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 6'b00_0000) begin errors++; $display("FAIL idle_halt: got %b expected %b", obs, 6'b00_0000); end
    endtask

    task automatic test_free_run();
        logic [5:0] e;
        logic [1:0] ph;
        int p;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            p = i % 3;
            ph = 2'(p + 1);
            e = {ph, p == 0, p == 1, p == 2, 1'b1};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL free_run_obs[%0d]: got %b expected %b", i, obs, e); end
            checks++;
            if (instret !== 32'(i / 3)) begin errors++; $display("FAIL free_run_instret[%0d]: got %0d expected %0d", i, instret, i / 3); end
            if (i == 11) run = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (obs !== 6'b00_0000) begin errors++; $display("FAIL free_run_halt: got %b expected %b", obs, 6'b00_0000); end
        checks++;
        if (instret !== 32'd4) begin errors++; $display("FAIL free_run_count: got %0d expected 4", instret); end
    endtask

    task automatic test_waits();
        logic [5:0] e;
        logic [1:0] ph;
        int p;
        do_reset();
        imem_wait = 4'd2;
        dmem_wait = 4'd1;
        run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            p = i % 6;
            ph = p < 3 ? 2'd1 : p < 5 ? 2'd2 : 2'd3;
            e = {ph, p == 0, p == 3, p == 5, 1'b1};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL waits_obs[%0d]: got %b expected %b", i, obs, e); end
            if (i == 1) imem_wait = 4'd0;
            if (i == 2) imem_wait = 4'd2;
            if (i == 3) dmem_wait = 4'd0;
            if (i == 4) dmem_wait = 4'd1;
            if (i == 11) run = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (obs !== 6'b00_0000) begin errors++; $display("FAIL waits_halt: got %b expected %b", obs, 6'b00_0000); end
        checks++;
        if (instret !== 32'd2) begin errors++; $display("FAIL waits_count: got %0d expected 2", instret); end
    endtask

    task automatic test_skip();
        logic [5:0] e;
        logic [1:0] ph_tab [10] = '{2'd1, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd1, 2'd2, 2'd3};
        logic [1:0] ph;
        do_reset();
        dmem_req = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ph = ph_tab[i];
            e = {ph, ph == 2'd1, ph == 2'd2, ph == 2'd3, 1'b1};
            checks++;
            if (obs_s !== e) begin errors++; $display("FAIL skip_obs[%0d]: got %b expected %b", i, obs_s, e); end
            if (ph == 2'd3) dmem_req = ~dmem_req;
            if (i == 9) run = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (obs_s !== 6'b00_0000) begin errors++; $display("FAIL skip_halt: got %b expected %b", obs_s, 6'b00_0000); end
        checks++;
        if (instret_s !== 32'd4) begin errors++; $display("FAIL skip_count: got %0d expected 4", instret_s); end
    endtask

    task automatic test_ready_stall();
        logic [5:0] e;
        do_reset();
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 6'b01_1001) begin errors++; $display("FAIL stall_fetch: got %b expected %b", obs, 6'b01_1001); end
        run = 1'b0;
        dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e = {2'd2, 1'b0, i == 0, 1'b0, 1'b1};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL stall_mem[%0d]: got %b expected %b", i, obs, e); end
            if (i == 4) dmem_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (obs !== 6'b11_0011) begin errors++; $display("FAIL stall_wb: got %b expected %b", obs, 6'b11_0011); end
        @(negedge clk);
        checks++;
        if (obs !== 6'b00_0000) begin errors++; $display("FAIL stall_halt: got %b expected %b", obs, 6'b00_0000); end
        checks++;
        if (instret !== 32'd1) begin errors++; $display("FAIL stall_count: got %0d expected 1", instret); end
    endtask

    task automatic test_step();
        do_reset();
        step = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 6'b01_1001) begin errors++; $display("FAIL step_fetch: got %b expected %b", obs, 6'b01_1001); end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        checks++;
        if (obs !== 6'b10_0101) begin errors++; $display("FAIL step_mem: got %b expected %b", obs, 6'b10_0101); end
        @(negedge clk);
        checks++;
        if (obs !== 6'b11_0011) begin errors++; $display("FAIL step_wb: got %b expected %b", obs, 6'b11_0011); end
        @(negedge clk);
        checks++;
        if (obs !== 6'b00_0000) begin errors++; $display("FAIL step_halt: got %b expected %b", obs, 6'b00_0000); end
        checks++;
        if (instret !== 32'd1) begin errors++; $display("FAIL step_count: got %0d expected 1", instret); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 6'b00_0000) begin errors++; $display("FAIL step_not_queued: got %b expected %b", obs, 6'b00_0000); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run = 1'b1;
        repeat (23) @(negedge clk);
        checks++;
        if (obs !== 6'b10_0101) begin errors++; $display("FAIL mid_pre_mem: got %b expected %b", obs, 6'b10_0101); end
        checks++;
        if (instret !== 32'd7) begin errors++; $display("FAIL mid_pre_count: got %0d expected 7", instret); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b00_0000) begin errors++; $display("FAIL mid_async_outputs: got %b expected %b", obs, 6'b00_0000); end
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL mid_async_count: got %0d expected 0", instret); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 6'b01_1001) begin errors++; $display("FAIL mid_restart: got %b expected %b", obs, 6'b01_1001); end
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (instret !== 32'd1) begin errors++; $display("FAIL mid_restart_count: got %0d expected 1", instret); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_waits();
        test_skip();
        test_ready_stall();
        test_step();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
